// File: rtl/riscky_pkg.sv
// rtl/riscky_pkg.sv - shared constants, state encoding and helpers for the fetch slice
package riscky_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-to-decode valid/ready instruction handshake
interface fetch_stage_if;
    import riscky_pkg::*;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        output out_valid, out_instr, out_pc, out_pc_plus4,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_instr, out_pc, out_pc_plus4,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO holding fetched {pc, instr} pairs
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // a full queue still accepts a push when the head leaves on the same edge
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // storage carries no reset; entries are meaningless until counted
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC sequencing, boot/run control and redirect handling in front of the fetch queue
module fetch_stage
    import riscky_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int              QDEPTH       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    fetch_stage_if.master    dec,
    output logic             misalign_err
);
    fetch_state_t            state_q;
    fetch_state_t            state_d;
    logic [XLEN-1:0]         pc_q;
    logic                    misalign_q;
    logic                    do_fetch;
    logic                    do_pop;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(QDEPTH):0] q_count;
    logic [2*XLEN-1:0]       q_head;

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;

    assign dec.out_valid    = !q_empty && !redirect_valid && !rst;
    assign dec.out_pc       = q_head[2*XLEN-1:XLEN];
    assign dec.out_pc_plus4 = q_head[2*XLEN-1:XLEN] + XLEN'(4);
    assign dec.out_instr    = (q_count == '0) ? INSTR_NOP : q_head[XLEN-1:0];
    assign do_pop           = dec.out_valid && dec.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // BOOT exists only to give instruction memory a settle cycle
    always_comb begin
        state_d  = state_q;
        do_fetch = 1'b0;
        case (state_q)
            BOOT:    state_d  = RUN;
            RUN:     do_fetch = !redirect_valid && (!q_full || do_pop);
            default: state_d  = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= align_pc(redirect_pc);
            misalign_q <= |redirect_pc[1:0];
        end else begin
            misalign_q <= 1'b0;
            if (do_fetch) pc_q <= pc_q + XLEN'(4);
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (do_fetch),
        .push_data ({pc_q, imem_rdata}),
        .pop       (do_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        misalign_err;
    int          n_checks;
    int          n_pass;

    fetch_stage_if dec ();

    fetch_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .QDEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec            (dec),
        .misalign_err   (misalign_err)
    );

    // memory word at byte address a is 0xC0DE0000 ^ a
    assign imem_rdata = 32'hC0DE_0000 ^ imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [31:0] pc);
        n_checks++;
        if (dec.out_valid !== 1'b1 || dec.out_pc !== pc || dec.out_pc_plus4 !== pc + 32'd4
            || dec.out_instr !== (32'hC0DE_0000 ^ pc)) begin
            $display("FAIL %s: valid=%b pc=%h pc4=%h instr=%h, need valid=1 pc=%h pc4=%h instr=%h",
                     name, dec.out_valid, dec.out_pc, dec.out_pc_plus4, dec.out_instr,
                     pc, pc + 32'd4, 32'hC0DE_0000 ^ pc);
        end else n_pass++;
    endtask

    task automatic check_idle(input string name, input logic [31:0] addr);
        n_checks++;
        if (dec.out_valid !== 1'b0 || imem_addr !== addr) begin
            $display("FAIL %s: valid=%b imem_addr=%h, need valid=0 imem_addr=%h",
                     name, dec.out_valid, imem_addr, addr);
        end else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec.out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (dec.out_valid !== 1'b0 || imem_addr !== 32'h0 || misalign_err !== 1'b0)
            $display("FAIL reset_state: valid=%b imem_addr=%h misalign=%b, need 0/00000000/0",
                     dec.out_valid, imem_addr, misalign_err);
        else n_pass++;
        rst = 1'b0;
    endtask

    // expects rst just released and out_ready high
    task automatic test_boot_seq(input string tag);
        step();
        check_idle({tag, "_boot_idle"}, 32'h0);
        step();
        check_head({tag, "_seq0"}, 32'h0);
        step();
        check_head({tag, "_seq1"}, 32'h4);
        step();
        check_head({tag, "_seq2"}, 32'h8);
    endtask

    task automatic test_backpressure;
        apply_reset();
        dec.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_head("bp_hold_head", 32'h0);
        n_checks++;
        if (imem_addr !== 32'h8)
            $display("FAIL bp_pc_frozen: imem_addr=%h, need 00000008", imem_addr);
        else n_pass++;
        dec.out_ready = 1'b1;
        step();
        check_head("bp_drain1", 32'h4);
        step();
        check_head("bp_drain2", 32'h8);
        step();
        check_head("bp_drain3", 32'hC);
    endtask

    task automatic test_redirect;
        apply_reset();
        dec.out_ready = 1'b0;
        step();
        step();
        step();
        check_head("rd_queued", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check_idle("rd_flushed", 32'h40);
        n_checks++;
        if (misalign_err !== 1'b0)
            $display("FAIL rd_aligned_noerr: misalign=%b, need 0", misalign_err);
        else n_pass++;
        step();
        check_head("rd_target", 32'h40);
    endtask

    task automatic test_misalign;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (misalign_err !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL ma_pulse: misalign=%b imem_addr=%h, need 1/00000040", misalign_err, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (misalign_err !== 1'b0)
            $display("FAIL ma_one_cycle: misalign=%b, need 0", misalign_err);
        else n_pass++;
    endtask

    task automatic test_redirect_transfer;
        apply_reset();
        dec.out_ready = 1'b1;
        step();
        step();
        check_head("rt_stream", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        #1;
        n_checks++;
        if (dec.out_valid !== 1'b0)
            $display("FAIL rt_no_transfer: valid=%b, need 0", dec.out_valid);
        else n_pass++;
        step();
        redirect_valid = 1'b0;
        check_idle("rt_flushed", 32'h80);
        step();
        check_head("rt_target", 32'h80);
    endtask

    task automatic test_wrap;
        dec.out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check_head("wrap_top", 32'hFFFF_FFFC);
        step();
        check_head("wrap_zero", 32'h0);
    endtask

    task automatic test_reset_full;
        apply_reset();
        dec.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_head("rf_full", 32'h0);
        rst = 1'b1;
        step();
        check_idle("rf_in_reset", 32'h0);
        rst = 1'b0;
        dec.out_ready = 1'b1;
        test_boot_seq("rf");
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_boot_seq("boot");
        test_backpressure();
        test_redirect();
        test_misalign();
        test_redirect_transfer();
        test_wrap();
        test_reset_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the fetch-queue entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, which is synchronous and active-high.
REQ-005 SHALL have port redirect_valid  input  1  meaning a branch/jump redirect request from downstream.
REQ-006 SHALL have port redirect_pc  input  32  meaning the redirect target address.
REQ-007 SHALL have port imem_addr  output  32  meaning the byte address to instruction memory, driven combinationally from the PC.
REQ-008 SHALL have port imem_rdata  input  32  meaning the instruction word returned combinationally by instruction memory.
REQ-009 SHALL have port out_valid  output  1  meaning a fetched instruction is presented to decode.
REQ-010 SHALL have port out_ready  input  1  meaning decode accepts the presented instruction.
REQ-011 SHALL have port out_instr  output  32  meaning the instruction word at the queue head.
REQ-012 SHALL have port out_pc  output  32  meaning the PC of out_instr.
REQ-013 SHALL have port out_pc_plus4  output  32  meaning out_pc+4, modulo 2^32.
REQ-014 SHALL have port misalign_err  output  1  meaning a one-cycle pulse flagging a redirect target with bits [1:0] != 0.

Function
REQ-015 SHALL implement a two-state FSM with states BOOT and RUN, where reset enters BOOT, BOOT goes to RUN after one cycle, and RUN holds until reset.
REQ-016 SHALL perform no fetch in BOOT, so the instruction memory has one settle cycle after reset release.
REQ-017 SHALL drive imem_addr = pc at all times.
REQ-018 SHALL fetch in RUN when no redirect is active and either count < QDEPTH or a dequeue occurs in the same cycle.
REQ-019 SHALL push {pc, imem_rdata} into the queue on each fetch and update pc <= pc+4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 SHALL define a dequeue as out_valid && out_ready, popping the head entry on that edge.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop, including when the queue is full.
REQ-022 SHALL hold pc and leave the queue unchanged (no push) when the queue is full and there is no pop.
REQ-023 SHALL drive out_valid = (count != 0) && !redirect_valid && !rst.
REQ-024 SHALL keep out_instr, out_pc and out_pc_plus4 stable while out_valid && !out_ready.
REQ-025 SHALL give redirect_valid the highest priority over stall, push and pop: on that edge the queue is cleared (count <= 0), pc <= {redirect_pc[31:2], 2'b00}, and no transfer occurs.
REQ-026 SHALL accept redirect_valid in BOOT, loading the target pc while the FSM still moves to RUN.
REQ-027 SHALL assert misalign_err for exactly the cycle after a redirect whose redirect_pc[1:0] != 0, and hold it at 0 otherwise.
REQ-028 SHALL have a fetch-to-decode latency of one cycle: an instruction fetched at edge N is presented with out_valid high after edge N.
REQ-029 SHALL sustain a throughput of one instruction per cycle while out_ready is held high.

Reset
REQ-030 SHALL, while rst is high at a clock edge, set pc <= RESET_VECTOR, state <= BOOT, count <= 0, queue pointers <= 0 and misalign_err <= 0.
REQ-031 SHALL drive out_valid = 0 during reset and on the first cycle after reset release.
REQ-032 SHALL discard all queued entries on reset asserted mid-operation, with no partial transfer.
REQ-033 SHALL not reset the queue storage data, which is don't-care while invalid.

Structure
REQ-034 SHALL take XLEN (32), RESET_VECTOR default, INSTR_NOP (32'h0000_0013) and the BOOT/RUN state encoding from shared package riscky_pkg.
REQ-035 SHALL place the queue in sub-module fetch_queue (synchronous FIFO with push, pop, clear, full, empty and count), with the FSM and PC in fetch_stage.

Verification
REQ-036 SHALL cover reset release with out_ready=1: cycle after release out_valid=0 and imem_addr=0x0; next cycles out_pc = 0x0, 0x4, 0x8 with out_instr = memory words 0, 1, 2.
REQ-037 SHALL cover backpressure with out_ready=0 for 5 cycles: queue holds 2 entries, pc frozen at 0x8, out_pc stable at 0x0; out_ready=1 then yields 0x0, 0x4, 0x8 with no duplicates or gaps.
REQ-038 SHALL cover redirect_valid=1, redirect_pc=0x40 with 2 entries queued: next cycle queue empty and imem_addr=0x40; following cycle out_pc=0x40, out_pc_plus4=0x44.
REQ-039 SHALL cover redirect_pc=0x42: pc=0x40 and misalign_err=1 for exactly one cycle.
REQ-040 SHALL cover redirect asserted together with out_valid && out_ready: no transfer is counted and the next delivered out_pc equals the target.
REQ-041 SHALL cover rst asserted with a full queue: next cycle out_valid=0 and pc=RESET_VECTOR; the fetch sequence then restarts exactly as in REQ-036.
